// File: rtl/usb_sched_pkg.sv
// Shared types and full-speed timing defaults for the USB host frame scheduler.
// Pure declarations: no latency, no flow control.
package usb_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ARB,
    ST_XFER,
    ST_EOF_WAIT
  } sched_state_e;

  localparam int FRAME_NUM_W = 11;
  localparam logic [FRAME_NUM_W-1:0] FRAME_NUM_MASK = 11'h7FF;

  localparam int FS_FRAME_CYCLES    = 48000;
  localparam int FS_CLKS_PER_BIT    = 4;
  localparam int FS_EOF_GUARD_BITS  = 32;
  localparam int FS_LEN_W           = 11;

  function automatic logic [FRAME_NUM_W-1:0] frame_next(input logic [FRAME_NUM_W-1:0] n);
    return (n + FRAME_NUM_W'(1)) & FRAME_NUM_MASK;
  endfunction

endpackage

// File: rtl/usb_sched_rr_arb.sv
// Round-robin pick: first set request at or after ptr, wrapping; one-hot plus index.
// Purely combinational, zero latency; no backpressure of its own.
module usb_sched_rr_arb
  import usb_sched_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx,
  output logic              vld
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int i = 0; i < NumReq; i++) begin
      k = (int'(ptr) + i) % NumReq;
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/usb_host_frame_sched.sv
// Full-speed USB host frame scheduler: 1 ms frames, one SOF per frame, round-robin grants bounded by EOF guard.
// Registered outputs, grant one cycle after arbitration; grants and SOF are held until their done pulse.
module usb_host_frame_sched
  import usb_sched_pkg::*;
#(
  parameter int NumReq       = 4,
  parameter int FrameCycles  = FS_FRAME_CYCLES,
  parameter int ClksPerBit   = FS_CLKS_PER_BIT,
  parameter int EofGuardBits = FS_EOF_GUARD_BITS,
  parameter int LenW         = FS_LEN_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NumReq-1:0]      req_i,
  input  logic [NumReq*LenW-1:0] req_len_i,
  output logic [NumReq-1:0]      gnt_o,
  input  logic                   done_i,
  output logic                   sof_req_o,
  output logic [FRAME_NUM_W-1:0] sof_frame_o,
  input  logic                   sof_done_i,
  output logic [15:0]            frame_cyc_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam logic [15:0]     LAST_CYC = 16'(FrameCycles - 1);
  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumReq - 1);

  sched_state_e           state;
  logic [15:0]            frame_cyc;
  logic [FRAME_NUM_W-1:0] frame_num;
  logic [IdxW-1:0]        rr_ptr;
  logic [IdxW-1:0]        gnt_idx;
  logic                   ovr_pend;

  logic                   wrap;
  logic [31:0]            remaining;
  logic [31:0]            need;
  logic [NumReq-1:0]      elig;
  logic [NumReq-1:0]      arb_gnt;
  logic [IdxW-1:0]        arb_idx;
  logic                   arb_vld;

  assign frame_cyc_o = frame_cyc;
  assign wrap        = (frame_cyc == LAST_CYC);
  assign remaining   = 32'(FrameCycles - 1) - 32'(frame_cyc);

  // A requester is eligible only if its worst case plus the EOF guard fits in what is left of the frame.
  always_comb begin
    elig = '0;
    need = '0;
    for (int k = 0; k < NumReq; k++) begin
      need    = (32'(req_len_i[k*LenW +: LenW]) + 32'(EofGuardBits)) * 32'(ClksPerBit);
      elig[k] = req_i[k] && (need <= remaining);
    end
  end

  usb_sched_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      frame_cyc   <= '0;
      frame_num   <= '0;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      ovr_pend    <= 1'b0;
      gnt_o       <= '0;
      sof_req_o   <= 1'b0;
      sof_frame_o <= '0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (state != ST_IDLE) begin
        frame_cyc <= wrap ? 16'd0 : frame_cyc + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          frame_cyc <= '0;
          if (enable_i) begin
            state       <= ST_SOF;
            sof_req_o   <= 1'b1;
            sof_frame_o <= frame_num;
            busy_o      <= 1'b1;
          end
        end

        ST_SOF: begin
          if (sof_done_i) begin
            frame_num <= frame_next(sof_frame_o);
            if (!enable_i) begin
              state     <= ST_IDLE;
              sof_req_o <= 1'b0;
              busy_o    <= 1'b0;
              frame_cyc <= '0;
            end else if (wrap) begin
              // A new frame begins on this very edge, so the next SOF follows without a gap.
              sof_frame_o <= frame_next(sof_frame_o);
            end else begin
              state     <= ST_ARB;
              sof_req_o <= 1'b0;
            end
          end
        end

        ST_ARB: begin
          if (!enable_i) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            frame_cyc <= '0;
          end else if (wrap) begin
            state       <= ST_SOF;
            sof_req_o   <= 1'b1;
            sof_frame_o <= frame_num;
          end else if (arb_vld) begin
            state   <= ST_XFER;
            gnt_o   <= arb_gnt;
            gnt_idx <= arb_idx;
          end else if (|req_i) begin
            state <= ST_EOF_WAIT;
          end
        end

        ST_XFER: begin
          if (wrap) begin
            overrun_o <= 1'b1;
            ovr_pend  <= 1'b1;
          end
          if (done_i) begin
            gnt_o    <= '0;
            ovr_pend <= 1'b0;
            rr_ptr   <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IdxW'(1);
            if (!enable_i) begin
              state     <= ST_IDLE;
              busy_o    <= 1'b0;
              frame_cyc <= '0;
            end else if (wrap || ovr_pend) begin
              state       <= ST_SOF;
              sof_req_o   <= 1'b1;
              sof_frame_o <= frame_num;
            end else begin
              state <= ST_ARB;
            end
          end
        end

        ST_EOF_WAIT: begin
          if (!enable_i) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            frame_cyc <= '0;
          end else if (wrap) begin
            state       <= ST_SOF;
            sof_req_o   <= 1'b1;
            sof_frame_o <= frame_num;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_host_frame_sched.sv
// Directed bench for usb_host_frame_sched with a 400-cycle frame: eligibility table plus sequences
// for SOF spacing, round-robin order, overrun, frame-number wrap and mid-transfer reset.
module tb_usb_host_frame_sched;

  localparam int NR = 4;
  localparam int LW = 11;

  logic           clk_i      = 1'b0;
  logic           rst_ni     = 1'b1;
  logic           enable_i   = 1'b0;
  logic [NR-1:0]  req_i      = '0;
  logic [NR*LW-1:0] req_len_i = '0;
  logic           done_i     = 1'b0;
  logic           sof_done_i = 1'b0;
  logic [NR-1:0]  gnt_o;
  logic           sof_req_o;
  logic [10:0]    sof_frame_o;
  logic [15:0]    frame_cyc_o;
  logic           overrun_o;
  logic           busy_o;

  usb_host_frame_sched #(
    .NumReq       (NR),
    .FrameCycles  (400),
    .ClksPerBit   (4),
    .EofGuardBits (8),
    .LenW         (LW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .req_i       (req_i),
    .req_len_i   (req_len_i),
    .gnt_o       (gnt_o),
    .done_i      (done_i),
    .sof_req_o   (sof_req_o),
    .sof_frame_o (sof_frame_o),
    .sof_done_i  (sof_done_i),
    .frame_cyc_o (frame_cyc_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int cyc;       // frame_cyc at which the request is first seen by ARB
    int idx;
    int len;
    bit gnt_now;
    bit gnt_after_sof;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_len(input int len);
    for (int k = 0; k < NR; k++) req_len_i[k*LW +: LW] = LW'(len);
  endtask

  task automatic wait_sof(input string name);
    int n;
    n = 0;
    while (!sof_req_o && n < 1000) begin
      tick();
      n++;
    end
    if (!sof_req_o) begin
      total++;
      $display("FAIL %s: sof_req_o never rose, waited %0d cycles", name, n);
    end
  endtask

  task automatic wait_cyc(input int c, input string name);
    int n;
    n = 0;
    while (frame_cyc_o != 16'(c) && n < 1000) begin
      tick();
      n++;
    end
    if (frame_cyc_o != 16'(c)) begin
      total++;
      $display("FAIL %s: frame_cyc_o %0d never reached %0d", name, frame_cyc_o, c);
    end
  endtask

  task automatic do_reset();
    enable_i   = 1'b0;
    req_i      = '0;
    done_i     = 1'b0;
    sof_done_i = 1'b0;
    rst_ni     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    bit bad;
    int n;
    int t0;
    logic [31:0] exp;

    //              cyc  idx  len   now after
    vecs[0] = '{ 167, 2,   50,  1'b1, 1'b0 };  // 232 needed, 232 left
    vecs[1] = '{ 168, 2,   50,  1'b0, 1'b1 };  // 231 left
    vecs[2] = '{ 170, 2,   50,  1'b0, 1'b1 };  // 229 left
    vecs[3] = '{ 363, 1,    1,  1'b1, 1'b0 };  // 36 needed, 36 left
    vecs[4] = '{ 364, 1,    1,  1'b0, 1'b1 };
    vecs[5] = '{  10, 3,    0,  1'b1, 1'b0 };
    vecs[6] = '{ 391, 0,    0,  1'b0, 1'b1 };  // 32 needed, 8 left
    vecs[7] = '{ 100, 1, 2047,  1'b0, 1'b0 };  // never fits a frame

    // Reset values, checked straight after the async assertion.
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_gnt",       32'(gnt_o),       32'd0);
    chk("rst_sof_req",   32'(sof_req_o),   32'd0);
    chk("rst_sof_frame", 32'(sof_frame_o), 32'd0);
    chk("rst_frame_cyc", 32'(frame_cyc_o), 32'd0);
    chk("rst_overrun",   32'(overrun_o),   32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);

    // Eligibility table: one request placed at a chosen frame position.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      enable_i = 1'b1;
      tick();
      chk("vec_sof_req", 32'(sof_req_o), 32'd1);
      sof_done_i = 1'b1;
      tick();
      sof_done_i = 1'b0;
      wait_cyc(vecs[i].cyc, "vec_wait_cyc");
      req_i = NR'(1 << vecs[i].idx);
      set_len(vecs[i].len);
      tick();
      exp = vecs[i].gnt_now ? (32'd1 << vecs[i].idx) : 32'd0;
      chk("vec_gnt_now", 32'(gnt_o), exp);
      if (vecs[i].gnt_now) begin
        req_i  = '0;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
      end else begin
        bad = 1'b0;
        n   = 0;
        while (!sof_req_o && n < 1000) begin
          if (gnt_o != '0) bad = 1'b1;
          tick();
          n++;
        end
        chk("vec_eof_hold", 32'(bad), 32'd0);
        chk("vec_next_sof", 32'(sof_req_o), 32'd1);
        sof_done_i = 1'b1;
        tick();
        sof_done_i = 1'b0;
        tick();
        exp = vecs[i].gnt_after_sof ? (32'd1 << vecs[i].idx) : 32'd0;
        chk("vec_gnt_after_sof", 32'(gnt_o), exp);
        req_i = '0;
        if (gnt_o != '0) begin
          done_i = 1'b1;
          tick();
          done_i = 1'b0;
        end
      end
    end

    // SOF spacing and frame numbering.
    do_reset();
    enable_i = 1'b1;
    wait_sof("sof1_wait");
    t0 = cyc_cnt;
    chk("sof1_frame", 32'(sof_frame_o), 32'd0);
    repeat (3) tick();
    sof_done_i = 1'b1;
    tick();
    sof_done_i = 1'b0;
    chk("sof1_drop", 32'(sof_req_o), 32'd0);
    wait_sof("sof2_wait");
    chk("sof_period",  32'(cyc_cnt - t0), 32'd400);
    chk("sof2_frame",  32'(sof_frame_o),  32'd1);
    chk("sof2_cyc",    32'(frame_cyc_o),  32'd0);

    // Round-robin order with all four requesting.
    sof_done_i = 1'b1;
    tick();
    sof_done_i = 1'b0;
    req_i = 4'hF;
    set_len(10);
    tick();
    chk("rr_first", 32'(gnt_o), 32'd1);
    for (int g = 0; g < 5; g++) begin
      repeat (4) tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("rr_gap", 32'(gnt_o), 32'd0);
      if (g < 4) begin
        tick();
        chk("rr_next", 32'(gnt_o), 32'd1 << ((g + 1) % 4));
      end
    end
    req_i = '0;

    // Overrun: grant late in the frame, done withheld past the wrap.
    wait_cyc(299, "ovr_wait_299");
    req_i = 4'b0001;
    tick();
    chk("ovr_gnt",     32'(gnt_o),       32'd1);
    chk("ovr_gnt_cyc", 32'(frame_cyc_o), 32'd300);
    req_i = '0;
    wait_cyc(0, "ovr_wait_wrap");
    chk("ovr_pulse",     32'(overrun_o), 32'd1);
    chk("ovr_gnt_held",  32'(gnt_o),     32'd1);
    chk("ovr_sof_early", 32'(sof_req_o), 32'd0);
    tick();
    chk("ovr_one_cycle", 32'(overrun_o), 32'd0);
    repeat (3) tick();
    chk("ovr_sof_wait",  32'(sof_req_o), 32'd0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("ovr_gnt_drop",  32'(gnt_o),       32'd0);
    chk("ovr_sof_after", 32'(sof_req_o),   32'd1);
    chk("ovr_sof_frame", 32'(sof_frame_o), 32'd2);

    // Async reset in the middle of a transfer.
    sof_done_i = 1'b1;
    tick();
    sof_done_i = 1'b0;
    req_i = 4'b0001;
    tick();
    chk("arst_pre_gnt", 32'(gnt_o), 32'd1);
    req_i = '0;
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_gnt",       32'(gnt_o),       32'd0);
    chk("arst_sof_req",   32'(sof_req_o),   32'd0);
    chk("arst_busy",      32'(busy_o),      32'd0);
    chk("arst_frame_cyc", 32'(frame_cyc_o), 32'd0);
    #2 rst_ni = 1'b1;
    wait_sof("arst_sof_wait");
    chk("arst_sof_frame", 32'(sof_frame_o), 32'd0);

    // Frame number 2047 wraps to 0; enable drop in ARB returns to IDLE keeping the number.
    do_reset();
    force dut.frame_num = 11'd2047;
    enable_i = 1'b1;
    tick();
    release dut.frame_num;
    chk("wrap_sof_2047", 32'(sof_frame_o), 32'd2047);
    sof_done_i = 1'b1;
    tick();
    sof_done_i = 1'b0;
    enable_i = 1'b0;
    tick();
    chk("wrap_idle_busy", 32'(busy_o),      32'd0);
    chk("wrap_idle_cyc",  32'(frame_cyc_o), 32'd0);
    enable_i = 1'b1;
    tick();
    chk("wrap_sof_req",   32'(sof_req_o),   32'd1);
    chk("wrap_sof_0",     32'(sof_frame_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
